// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and coordinate type, used by the timing generator
// and by downstream renderers that need the same frame geometry.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel coordinates, display enable, syncs and frame markers.
interface vga_timing_gen_if;
    import vga_pkg::*;

    coord_t     DrawX;
    coord_t     DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, frame_start, frame_count
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N counter with count enable; wrap pulses on the enabled cycle that
// returns the count to zero.
module mod_counter #(
    parameter int MODULUS = 800,
    parameter int W       = 10
) (
    input  logic         vga_clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MODULUS - 1));

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters decoded into
// registered coordinates, display enable, active-low syncs and frame markers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t hc;
    coord_t vc;
    logic   h_wrap;
    logic   v_wrap;
    logic   at_origin;

    mod_counter #(
        .MODULUS (H_TOTAL),
        .W       (COORD_W)
    ) u_hcnt (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (1'b1),
        .count   (hc),
        .wrap    (h_wrap)
    );

    mod_counter #(
        .MODULUS (V_TOTAL),
        .W       (COORD_W)
    ) u_vcnt (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (h_wrap),
        .count   (vc),
        .wrap    (v_wrap)
    );

    // The horizontal counter never stalls, so (hc,vc) returns to the origin
    // exactly on the cycle after a vertical wrap (or after reset).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            at_origin <= 1'b1;
        end else begin
            at_origin <= v_wrap;
        end
    end

    // ---- stage p0: combinational decode of the current (hc,vc) ----
    logic blank_p0;
    logic hs_p0;
    logic vs_p0;

    always_comb begin
        blank_p0 = 1'b0;
        hs_p0    = 1'b1;
        vs_p0    = 1'b1;
        if ((hc < H_ACT_C) && (vc < V_ACT_C)) begin
            blank_p0 = 1'b1;
        end
        if ((hc >= HS_START) && (hc < HS_END)) begin
            hs_p0 = 1'b0;
        end
        if ((vc >= VS_START) && (vc < VS_END)) begin
            vs_p0 = 1'b0;
        end
    end

    // ---- stage p1: registered outputs, all describing the same pixel ----
    coord_t     draw_x_p1;
    coord_t     draw_y_p1;
    logic       blank_p1;
    logic       hs_p1;
    logic       vs_p1;
    logic       frame_start_p1;
    logic [7:0] frame_count_p1;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            draw_x_p1      <= '0;
            draw_y_p1      <= '0;
            blank_p1       <= 1'b0;
            hs_p1          <= 1'b1;
            vs_p1          <= 1'b1;
            frame_start_p1 <= 1'b0;
            frame_count_p1 <= '0;
        end else begin
            draw_x_p1      <= hc;
            draw_y_p1      <= vc;
            blank_p1       <= blank_p0;
            hs_p1          <= hs_p0;
            vs_p1          <= vs_p0;
            frame_start_p1 <= at_origin;
            if (at_origin) begin
                frame_count_p1 <= frame_count_p1 + 8'd1;
            end
        end
    end

    assign vga.DrawX       = draw_x_p1;
    assign vga.DrawY       = draw_y_p1;
    assign vga.blank       = blank_p1;
    assign vga.hs          = hs_p1;
    assign vga.vs          = vs_p1;
    assign vga.frame_start = frame_start_p1;
    assign vga.frame_count = frame_count_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 12x7 instance
// share clock and reset; both are compared every cycle against a raster model.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen_if big_if ();
    vga_timing_gen_if sm_if ();

    vga_timing_gen dut_big (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (big_if)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) dut_sm (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (sm_if)
    );

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Raster geometry of the two instances: index 0 = default, 1 = tiny.
    int HA[2]  = '{640, 8};
    int HFP[2] = '{16, 1};
    int HSY[2] = '{96, 2};
    int HT[2]  = '{800, 12};
    int VA[2]  = '{480, 4};
    int VFP[2] = '{10, 1};
    int VSY[2] = '{2, 1};
    int VT[2]  = '{525, 7};

    // Model: number of pixels emitted since reset release; outputs describe pixel m_cur.
    longint m_n[2];
    longint m_cur[2];
    bit     m_rst[2];
    bit     m_valid = 1'b0;

    always @(posedge vga_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_rst[i] <= 1'b1;
                m_n[i]   <= 0;
            end else begin
                m_rst[i] <= 1'b0;
                m_cur[i] <= m_n[i];
                m_n[i]   <= m_n[i] + 1;
            end
        end
        m_valid <= 1'b1;
    end

    task automatic chk_inst(input int i, input string p, input logic [9:0] x, input logic [9:0] y,
                            input logic b, input logic h, input logic v, input logic f,
                            input logic [7:0] fc);
        int ex, ey, eb, eh, ev, ef, efc;
        if (m_rst[i]) begin
            ex = 0; ey = 0; eb = 0; eh = 1; ev = 1; ef = 0; efc = 0;
        end else begin
            ex  = int'(m_cur[i] % HT[i]);
            ey  = int'((m_cur[i] / HT[i]) % VT[i]);
            eb  = (ex < HA[i] && ey < VA[i]) ? 1 : 0;
            eh  = (ex >= HA[i] + HFP[i] && ex < HA[i] + HFP[i] + HSY[i]) ? 0 : 1;
            ev  = (ey >= VA[i] + VFP[i] && ey < VA[i] + VFP[i] + VSY[i]) ? 0 : 1;
            ef  = (ex == 0 && ey == 0) ? 1 : 0;
            efc = int'(((m_cur[i] / (HT[i] * VT[i])) + 1) % 256);
        end
        cmp({p, ".DrawX"}, 32'(x), 32'(ex));
        cmp({p, ".DrawY"}, 32'(y), 32'(ey));
        cmp({p, ".blank"}, 32'(b), 32'(eb));
        cmp({p, ".hs"}, 32'(h), 32'(eh));
        cmp({p, ".vs"}, 32'(v), 32'(ev));
        cmp({p, ".frame_start"}, 32'(f), 32'(ef));
        cmp({p, ".frame_count"}, 32'(fc), 32'(efc));
    endtask

    always @(negedge vga_clk) begin
        if (m_valid) begin
            chk_inst(0, "big", big_if.DrawX, big_if.DrawY, big_if.blank, big_if.hs, big_if.vs,
                     big_if.frame_start, big_if.frame_count);
            chk_inst(1, "sm", sm_if.DrawX, sm_if.DrawY, sm_if.blank, sm_if.hs, sm_if.vs,
                     sm_if.frame_start, sm_if.frame_count);
        end
    end

    task automatic first_pixel_sm(input string p);
        cmp({p, ".DrawX"}, 32'(sm_if.DrawX), 0);
        cmp({p, ".DrawY"}, 32'(sm_if.DrawY), 0);
        cmp({p, ".blank"}, 32'(sm_if.blank), 1);
        cmp({p, ".frame_start"}, 32'(sm_if.frame_start), 1);
        cmp({p, ".frame_count"}, 32'(sm_if.frame_count), 1);
        cmp({p, ".hs"}, 32'(sm_if.hs), 1);
        cmp({p, ".vs"}, 32'(sm_if.vs), 1);
    endtask

    initial begin
        int fall_x, hs_cnt, hs_first, prev_blank, found, period;
        int vs_cnt, vs_bad, hs_cnt_f, hs_bad, blank_bad;
        int n_fs, prev_fc, seq_bad, wrap_seen, fc_hist0, fc_hist1;

        // Reset for three edges, then release.
        repeat (3) @(negedge vga_clk);
        cmp("rst.sm.DrawX", 32'(sm_if.DrawX), 0);
        cmp("rst.sm.blank", 32'(sm_if.blank), 0);
        cmp("rst.sm.hs", 32'(sm_if.hs), 1);
        cmp("rst.sm.vs", 32'(sm_if.vs), 1);
        cmp("rst.sm.frame_count", 32'(sm_if.frame_count), 0);
        reset = 1'b0;
        @(negedge vga_clk);
        first_pixel_sm("first.sm");
        cmp("first.big.blank", 32'(big_if.blank), 1);
        cmp("first.big.frame_start", 32'(big_if.frame_start), 1);
        cmp("first.big.frame_count", 32'(big_if.frame_count), 1);

        // One full line of the default instance.
        fall_x = -1; hs_cnt = 0; hs_first = -1; prev_blank = int'(big_if.blank);
        for (int i = 1; i <= 800; i++) begin
            @(negedge vga_clk);
            if (prev_blank == 1 && !big_if.blank && fall_x < 0) fall_x = int'(big_if.DrawX);
            prev_blank = int'(big_if.blank);
            if (big_if.DrawY == 0 && !big_if.hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(big_if.DrawX);
            end
            if (i == 799) begin
                cmp("line.x799", 32'(big_if.DrawX), 799);
                cmp("line.y0", 32'(big_if.DrawY), 0);
            end
            if (i == 800) begin
                cmp("line.wrap_x", 32'(big_if.DrawX), 0);
                cmp("line.wrap_y", 32'(big_if.DrawY), 1);
            end
        end
        cmp("line.blank_fall_x", 32'(fall_x), 640);
        cmp("line.hs_low_cycles", 32'(hs_cnt), 96);
        cmp("line.hs_first_x", 32'(hs_first), 656);

        // One full frame of the tiny instance, between consecutive frame_start pulses.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge vga_clk);
            if (sm_if.frame_start) found = 1;
        end
        cmp("frame.fs_seen", 32'(found), 1);
        period = 0; found = 0; vs_cnt = 0; vs_bad = 0; hs_cnt_f = 0; hs_bad = 0; blank_bad = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!sm_if.vs) begin
                vs_cnt++;
                if (sm_if.DrawY != 5) vs_bad++;
            end
            if (!sm_if.hs) begin
                hs_cnt_f++;
                if (sm_if.DrawX != 9 && sm_if.DrawX != 10) hs_bad++;
            end
            if (sm_if.blank && sm_if.DrawY >= 4) blank_bad++;
            @(negedge vga_clk);
            period++;
            if (sm_if.frame_start) found = 1;
        end
        cmp("frame.period", 32'(period), 84);
        cmp("frame.vs_low_cycles", 32'(vs_cnt), 12);
        cmp("frame.vs_wrong_line", 32'(vs_bad), 0);
        cmp("frame.hs_low_cycles", 32'(hs_cnt_f), 14);
        cmp("frame.hs_wrong_x", 32'(hs_bad), 0);
        cmp("frame.blank_in_vblank", 32'(blank_bad), 0);

        // 258 consecutive frame_start pulses: frame_count steps by one and wraps.
        n_fs = 0; prev_fc = -1; seq_bad = 0; wrap_seen = 0; fc_hist0 = -1; fc_hist1 = -1;
        for (int i = 0; i < 258 * 84 + 200 && n_fs < 258; i++) begin
            @(negedge vga_clk);
            if (sm_if.frame_start) begin
                if (prev_fc >= 0 && int'(sm_if.frame_count) != ((prev_fc + 1) % 256)) seq_bad++;
                if (fc_hist0 == 255 && fc_hist1 == 0 && sm_if.frame_count == 1) wrap_seen = 1;
                fc_hist0 = fc_hist1;
                fc_hist1 = int'(sm_if.frame_count);
                if (fc_hist1 == 0 && prev_fc == 255) fc_hist0 = 255;
                prev_fc = int'(sm_if.frame_count);
                n_fs++;
            end
        end
        cmp("fc.pulses", 32'(n_fs), 258);
        cmp("fc.skipped", 32'(seq_bad), 0);
        cmp("fc.wrap_255_0_1", 32'(wrap_seen), 1);

        // Reset in the middle of both sync pulses of the tiny instance.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge vga_clk);
            if (sm_if.DrawX == 10 && sm_if.DrawY == 5) found = 1;
        end
        cmp("midrst.reached", 32'(found), 1);
        cmp("midrst.hs_before", 32'(sm_if.hs), 0);
        cmp("midrst.vs_before", 32'(sm_if.vs), 0);
        reset = 1'b1;
        @(negedge vga_clk);
        cmp("midrst.hs", 32'(sm_if.hs), 1);
        cmp("midrst.vs", 32'(sm_if.vs), 1);
        cmp("midrst.blank", 32'(sm_if.blank), 0);
        cmp("midrst.DrawX", 32'(sm_if.DrawX), 0);
        cmp("midrst.DrawY", 32'(sm_if.DrawY), 0);
        cmp("midrst.frame_count", 32'(sm_if.frame_count), 0);
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        first_pixel_sm("midrst.release");

        // Reset during horizontal sync of the default instance.
        found = 0;
        for (int i = 0; i < 900 && !found; i++) begin
            @(negedge vga_clk);
            if (big_if.DrawX == 700) found = 1;
        end
        cmp("bigrst.reached", 32'(found), 1);
        cmp("bigrst.hs_before", 32'(big_if.hs), 0);
        reset = 1'b1;
        @(negedge vga_clk);
        cmp("bigrst.hs", 32'(big_if.hs), 1);
        cmp("bigrst.DrawX", 32'(big_if.DrawX), 0);
        reset = 1'b0;

        // Random run lengths interleaved with random reset pulses.
        for (int k = 0; k < 15; k++) begin
            repeat ($urandom_range(1, 400)) @(negedge vga_clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge vga_clk);
            reset = 1'b0;
        end
        repeat (100) @(negedge vga_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 The design SHALL use exactly one clock and a synchronous, active-high reset.
REQ-010 Port vga_clk, input, 1, pixel clock (25 MHz nominal); all logic on its rising edge.
REQ-011 Port reset, input, 1, synchronous active-high reset.
REQ-012 Port DrawX, output, 10, horizontal position of the current pixel (0..H_TOTAL-1).
REQ-013 Port DrawY, output, 10, vertical position of the current line (0..V_TOTAL-1).
REQ-014 Port blank, output, 1, high = current pixel is visible (display enable), low = blanking.
REQ-015 Port hs, output, 1, horizontal sync, active low.
REQ-016 Port vs, output, 1, vertical sync, active low.
REQ-017 Port frame_start, output, 1, one-cycle pulse marking pixel (0,0).
REQ-018 Port frame_count, output, 8, number of frames started since reset, modulo 256.

Function
REQ-019 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
REQ-020 Internal counter hc SHALL increment by 1 each clock and wrap from H_TOTAL-1 to 0.
REQ-021 Internal counter vc SHALL increment by 1 only on the cycle hc wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-022 All outputs SHALL be registered decodes of the (hc,vc) held in the previous cycle: fixed latency of 1 clock; DrawX/DrawY/blank/hs/vs/frame_start always describe the same pixel.
REQ-023 blank SHALL be 1 iff DrawX < H_ACTIVE and DrawY < V_ACTIVE.
REQ-024 hs SHALL be 0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC (656..751 default).
REQ-025 vs SHALL be 0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC (490..491 default), for all DrawX in those lines.
REQ-026 frame_start SHALL be 1 for exactly the one cycle in which DrawX=0 and DrawY=0.
REQ-027 frame_count SHALL increment by 1, wrapping 255->0, on the cycle frame_start is asserted.
REQ-028 Period of frame_start SHALL be exactly H_TOTAL*V_TOTAL clocks (420000 default).

Reset
REQ-029 While reset is high at a rising edge: hc=0, vc=0, DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, frame_count=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately; no partial sync pulse SHALL remain asserted in the cycle after reset is sampled.
REQ-031 On the first edge after reset deasserts, outputs SHALL present pixel (0,0): blank=1, frame_start=1, frame_count=1; hc advances to 1.

Structure
REQ-032 Timing defaults, H_TOTAL/V_TOTAL derivations and coordinate width SHALL live in shared package vga_pkg, also used by downstream sprite/ROM renderers.
REQ-033 One sub-module mod_counter (parameterised modulus, enable in, wrap-pulse out) SHALL be instantiated twice: horizontal (always enabled) and vertical (enabled by horizontal wrap).

Verification
REQ-034 Reset for 3 cycles then release -> first output cycle DrawX=0, DrawY=0, blank=1, frame_start=1, frame_count=1, hs=1, vs=1.
REQ-035 Run one line -> blank falls at DrawX=640, hs low for exactly 96 cycles starting DrawX=656, DrawX wraps 799->0 with DrawY 0->1.
REQ-036 Run one full frame -> vs low exactly on DrawY=490 and 491 (1600 cycles), blank never high for DrawY>=480, next frame_start exactly 420000 cycles after the first.
REQ-037 Run 257 frames -> frame_count sequence wraps 255->0->1 with no skipped value.
REQ-038 Assert reset at DrawX=700, DrawY=490 (hs and vs low) -> next cycle hs=1, vs=1, blank=0, counters 0; after release behaves as REQ-034.
REQ-039 Instantiate with H_ACTIVE=8,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1 -> frame period 12*7=84 cycles, hs low at DrawX 9..10, vs low at DrawY 5.
